// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment scan driver with per-frame digit snapshot.
// Latency: an/seg/frame_start are registered, one clkm cycle after the (cnt, idx) scan state.
// Backpressure: none; free-running scan, en only blanks the outputs and never stalls the scan.
module seg_scan_driver #(
  parameter int DIV = 50000,
  parameter int GAP = 500
) (
  input  logic       clkm,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] Din0,
  input  logic [3:0] Din1,
  input  logic [3:0] Din2,
  input  logic [3:0] Din3,
  input  logic [3:0] Din4,
  input  logic [3:0] Din5,
  input  logic [3:0] Din6,
  input  logic [3:0] Din7,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_start
);

  // Counter width; DIV >= 2 so at least one bit is needed.
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [3:0] BLANK_CODE = 4'd10;

  // Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      4'd11:   pat = 7'h3F;  // '-'
      4'd12:   pat = 7'h06;  // 'E'
      default: pat = 7'h7F;  // 10 and 13..15 are blank
    endcase
    return pat;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    snap_q [8];
  logic [3:0]    snap_d [8];
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_start_q, frame_start_d;

  logic [3:0]    din [8];
  logic          tick;
  logic          lit;

  assign din[0] = Din0;
  assign din[1] = Din1;
  assign din[2] = Din2;
  assign din[3] = Din3;
  assign din[4] = Din4;
  assign din[5] = Din5;
  assign din[6] = Din6;
  assign din[7] = Din7;

  // Next-state: prescaler, scan index, frame snapshot and registered display outputs.
  always_comb begin
    tick          = (cnt_q == CW'(DIV - 1));
    // The dead-time gap occupies the first GAP cycles of every digit period.
    lit           = en && (int'(cnt_q) >= GAP);
    cnt_d         = tick ? '0 : cnt_q + CW'(1);
    idx_d         = tick ? idx_q + 3'd1 : idx_q;
    // Snapshot on the last cycle of digit 7 so a whole frame shows one consistent set.
    frame_start_d = tick && (idx_q == 3'd7);
    for (int k = 0; k < 8; k++) begin
      snap_d[k] = frame_start_d ? din[k] : snap_q[k];
    end
    an_d  = lit ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d = lit ? decode(snap_q[idx_q]) : 7'h7F;
  end

  // State register with synchronous active-low reset; reset drops any frame in progress.
  always_ff @(posedge clkm) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      frame_start_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        snap_q[k] <= BLANK_CODE;
      end
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
      for (int k = 0; k < 8; k++) begin
        snap_q[k] <= snap_d[k];
      end
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: u0 runs DIV=4/GAP=1, u1 runs the DIV=2/GAP=0 boundary case.
// A cycle model pushes expected outputs per edge; a monitor pops and compares them.
// Scenario tasks add direct checks with hand-derived constants.
module tb_seg_scan_driver;

  localparam int PDIV [2] = '{4, 2};
  localparam int PGAP [2] = '{1, 0};
  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h3F, 7'h06, 7'h7F, 7'h7F, 7'h7F
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  logic       clkm;
  logic       rst_n;
  logic       en;
  logic [3:0] din [8];
  logic [6:0] seg0, seg1;
  logic [7:0] an0, an1;
  logic       fs0, fs1;

  int n_chk;
  int n_pass;
  int cc;
  exp_t q0 [$];
  exp_t q1 [$];

  int m_cnt  [2];
  int m_idx  [2];
  int m_snap [2][8];

  seg_scan_driver #(.DIV(4), .GAP(1)) u0 (
    .clkm(clkm), .rst_n(rst_n), .en(en),
    .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
    .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
    .seg(seg0), .an(an0), .frame_start(fs0)
  );

  seg_scan_driver #(.DIV(2), .GAP(0)) u1 (
    .clkm(clkm), .rst_n(rst_n), .en(en),
    .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
    .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
    .seg(seg1), .an(an1), .frame_start(fs1)
  );

  initial clkm = 1'b0;
  always #5 clkm = ~clkm;

  // Reference model: on each edge, predict the registered outputs and push them.
  initial begin
    exp_t e;
    logic lit;
    logic tk;
    forever begin
      @(posedge clkm);
      for (int p = 0; p < 2; p++) begin
        if (!rst_n) begin
          e = '{an: 8'hFF, seg: 7'h7F, fs: 1'b0};
          m_cnt[p] = 0;
          m_idx[p] = 0;
          for (int k = 0; k < 8; k++) m_snap[p][k] = 10;
        end else begin
          lit   = en && (m_cnt[p] >= PGAP[p]);
          e.an  = lit ? ~(8'b1 << m_idx[p]) : 8'hFF;
          e.seg = lit ? DEC[m_snap[p][m_idx[p]]] : 7'h7F;
          tk    = (m_cnt[p] == PDIV[p] - 1);
          e.fs  = tk && (m_idx[p] == 7);
          if (e.fs) for (int k = 0; k < 8; k++) m_snap[p][k] = int'(din[k]);
          m_cnt[p] = tk ? 0 : m_cnt[p] + 1;
          if (tk) m_idx[p] = (m_idx[p] + 1) % 8;
        end
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  end

  // Scoreboard monitor: compare DUT outputs against the predictions for this edge.
  initial begin
    exp_t ge;
    forever begin
      @(posedge clkm);
      #1;
      while (q0.size() > 0) begin
        ge = q0.pop_front();
        n_chk++;
        if ({an0, seg0, fs0} !== ge)
          $display("FAIL sb_u0 got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b",
                   an0, seg0, fs0, ge.an, ge.seg, ge.fs);
        else n_pass++;
      end
      while (q1.size() > 0) begin
        ge = q1.pop_front();
        n_chk++;
        if ({an1, seg1, fs1} !== ge)
          $display("FAIL sb_u1 got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b",
                   an1, seg1, fs1, ge.an, ge.seg, ge.fs);
        else n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge clkm);
    #1;
    cc++;
  endtask

  // Expected u0 anode pattern from the scan phase (cc counts edges since reset release).
  function automatic logic [7:0] phase_an(input int c);
    return ((c % 4) == 0) ? 8'hFF : ~(8'b1 << ((c / 4) % 8));
  endfunction

  task automatic test_reset();
    repeat (3) cyc();
    n_chk++; if (an0 !== 8'hFF) $display("FAIL reset_an got %h want ff", an0); else n_pass++;
    n_chk++; if (seg0 !== 7'h7F) $display("FAIL reset_seg got %h want 7f", seg0); else n_pass++;
    n_chk++; if (fs0 !== 1'b0) $display("FAIL reset_fs got %b want 0", fs0); else n_pass++;
    n_chk++; if (an1 !== 8'hFF) $display("FAIL reset_an_u1 got %h want ff", an1); else n_pass++;
  endtask

  task automatic test_first_frame();
    int fs_at;
    int k;
    logic [6:0] want_seg;
    fs_at = -1;
    rst_n = 1'b1;
    cc = -1;
    for (int i = 0; i < 32; i++) begin
      cyc();
      n_chk++;
      if (seg0 !== 7'h7F) $display("FAIL ff0_seg c=%0d got %h want 7f", cc, seg0); else n_pass++;
      n_chk++;
      if (!(an0 === 8'hFF || $countones(~an0) == 1))
        $display("FAIL ff0_an c=%0d got %h want ff or one-low", cc, an0);
      else n_pass++;
      if (fs0 === 1'b1 && fs_at < 0) fs_at = cc;
    end
    n_chk++;
    if (fs_at != 31) $display("FAIL ff0_fs_cycle got %0d want 31", fs_at); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      cyc();
      k = (cc / 4) % 8;
      want_seg = ((cc % 4) == 0) ? 7'h7F : DEC[k];
      n_chk++;
      if (an0 !== phase_an(cc)) $display("FAIL ff1_an c=%0d got %h want %h", cc, an0, phase_an(cc));
      else n_pass++;
      n_chk++;
      if (seg0 !== want_seg) $display("FAIL ff1_seg c=%0d got %h want %h", cc, seg0, want_seg);
      else n_pass++;
    end
  endtask

  task automatic test_dead_time();
    int ff_cnt;
    for (int p = 0; p < 8; p++) begin
      ff_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        cyc();
        if (an0 === 8'hFF) ff_cnt++;
        else if ($countones(~an0) != 1) ff_cnt = 99;
      end
      n_chk++;
      if (ff_cnt != 1) $display("FAIL dead_time period=%0d got %0d off-cycles want 1", p, ff_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_tearing();
    logic seen_fs;
    logic seen_old;
    logic seen_new;
    logic [6:0] want;
    seen_fs = 1'b0; seen_old = 1'b0; seen_new = 1'b0;
    for (int i = 0; i < 64 && an0 !== 8'hFD; i++) cyc();
    n_chk++;
    if (an0 !== 8'hFD) $display("FAIL tear_wait got an=%h want fd", an0); else n_pass++;
    din[3] = 4'd9;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (fs0 === 1'b1) seen_fs = 1'b1;
      if (an0 === 8'hF7) begin
        want = seen_fs ? 7'h10 : 7'h30;
        if (seen_fs) seen_new = 1'b1; else seen_old = 1'b1;
        n_chk++;
        if (seg0 !== want) $display("FAIL tear_d3 c=%0d got %h want %h", cc, seg0, want);
        else n_pass++;
      end
    end
    n_chk++;
    if (!(seen_old && seen_new))
      $display("FAIL tear_cover got old=%b new=%b want 1 1", seen_old, seen_new);
    else n_pass++;
  endtask

  task automatic test_special();
    int hits;
    logic [6:0] want;
    hits = 0;
    din[0] = 4'd10; din[1] = 4'd11; din[2] = 4'd12; din[3] = 4'd15;
    for (int i = 0; i < 40 && fs0 !== 1'b1; i++) cyc();
    n_chk++;
    if (fs0 !== 1'b1) $display("FAIL spec_wait got fs=%b want 1", fs0); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      cyc();
      want = 7'h00;
      case (an0)
        8'hFE: want = 7'h7F;
        8'hFD: want = 7'h3F;
        8'hFB: want = 7'h06;
        8'hF7: want = 7'h7F;
        default: want = 7'h00;
      endcase
      if (want != 7'h00) begin
        hits++;
        n_chk++;
        if (seg0 !== want) $display("FAIL spec_seg an=%h got %h want %h", an0, seg0, want);
        else n_pass++;
      end
    end
    n_chk++;
    if (hits != 12) $display("FAIL spec_hits got %0d want 12", hits); else n_pass++;
  endtask

  task automatic test_enable();
    for (int i = 0; i < 64 && an0 !== 8'hFB; i++) cyc();
    n_chk++;
    if (an0 !== 8'hFB) $display("FAIL en_wait got an=%h want fb", an0); else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_chk++;
      if (an0 !== 8'hFF || seg0 !== 7'h7F || an1 !== 8'hFF)
        $display("FAIL en_off c=%0d got an=%h seg=%h an1=%h want ff 7f ff", cc, an0, seg0, an1);
      else n_pass++;
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if (an0 !== phase_an(cc)) $display("FAIL en_resume c=%0d got %h want %h", cc, an0, phase_an(cc));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int fs_at;
    fs_at = -1;
    for (int i = 0; i < 64 && an0 !== 8'hDF; i++) cyc();
    n_chk++;
    if (an0 !== 8'hDF) $display("FAIL rmid_wait got an=%h want df", an0); else n_pass++;
    rst_n = 1'b0;
    cyc();
    n_chk++;
    if (an0 !== 8'hFF || seg0 !== 7'h7F || fs0 !== 1'b0)
      $display("FAIL rmid_out got an=%h seg=%h fs=%b want ff 7f 0", an0, seg0, fs0);
    else n_pass++;
    rst_n = 1'b1;
    cc = -1;
    for (int i = 0; i < 32; i++) begin
      cyc();
      n_chk++;
      if (seg0 !== 7'h7F || an0 !== phase_an(cc))
        $display("FAIL rmid_frame c=%0d got an=%h seg=%h want %h 7f", cc, an0, seg0, phase_an(cc));
      else n_pass++;
      if (fs0 === 1'b1 && fs_at < 0) fs_at = cc;
    end
    n_chk++;
    if (fs_at != 31) $display("FAIL rmid_fs_cycle got %0d want 31", fs_at); else n_pass++;
  endtask

  task automatic test_div2();
    int nfs;
    int noff;
    nfs = 0; noff = 0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (fs1 === 1'b1) nfs++;
      if (an1 === 8'hFF) noff++;
    end
    n_chk++;
    if (nfs != 3) $display("FAIL div2_fs got %0d want 3", nfs); else n_pass++;
    n_chk++;
    if (noff != 0) $display("FAIL gap0_off got %0d want 0", noff); else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cc = 0;
    rst_n = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 8; k++) din[k] = 4'(k);
    test_reset();
    test_first_frame();
    test_dead_time();
    test_tearing();
    test_special();
    test_enable();
    test_reset_mid();
    test_div2();
    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
